// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and Gray/binary conversion helpers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 3;
  localparam int unsigned CONV_W      = 32;

  // Width-agnostic: callers zero-extend into CONV_W bits and cast the result back.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b = '0;
    for (int i = 0; i < int'(CONV_W); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_ff_chain #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg_q [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign q = stg_q[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer block of the async FIFO: write pointer, synchronized read
// pointer, full/almost_full/level and overflow generation.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W      = FIFO_ADDR_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AFULL_TH    = 6
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   w_ptr_gray,
  output logic              mem_we,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int unsigned      PTR_W      = ADDR_W + 1;
  // Full when the write pointer leads the read pointer by one full lap: top two Gray bits inverted.
  localparam logic [PTR_W-1:0] FULL_MASK  = PTR_W'(3) << (PTR_W - 2);
  localparam logic [PTR_W-1:0] AFULL_TH_P = PTR_W'(AFULL_TH);

  logic [PTR_W-1:0] w_bin_q,  w_bin_d;
  logic [PTR_W-1:0] w_gray_q, w_gray_d;
  logic [PTR_W-1:0] level_q,  level_d;
  logic             full_q,   full_d;
  logic             afull_q,  afull_d;
  logic             ovf_q,    ovf_d;
  logic [PTR_W-1:0] rq;
  logic [PTR_W-1:0] rq_bin;
  logic             accept;

  sync_ff_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (w_clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rq)
  );

  assign rq_bin = PTR_W'(gray2bin(CONV_W'(rq)));
  assign accept = wr_en & ~full_q & rst;

  // Next-state: pointer advance and flags computed from the post-write pointer.
  always_comb begin
    w_bin_d  = w_bin_q;
    w_gray_d = w_gray_q;
    if (accept) begin
      w_bin_d  = w_bin_q + PTR_W'(1);
      w_gray_d = PTR_W'(bin2gray(CONV_W'(w_bin_d)));
    end
    level_d = w_bin_d - rq_bin;
    full_d  = (w_gray_d == (rq ^ FULL_MASK));
    afull_d = (level_d >= AFULL_TH_P);
    ovf_d   = wr_en & full_q;
  end

  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      w_bin_q  <= '0;
      w_gray_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      w_bin_q  <= w_bin_d;
      w_gray_q <= w_gray_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign w_addr      = w_bin_q[ADDR_W-1:0];
  assign w_ptr_gray  = w_gray_q;
  assign mem_we      = accept;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule
